temp_spi_sampler: RTL and testbench
===================================

Name: temp_spi_sampler

Overview:
Periodic acquisition controller for a 16-bit SPI temperature sensor (mode 0, read-only, MSB first). It sequences chip-select, SCK and MISO capture on a programmable schedule or an on-demand trigger, and holds the last sample on a 16-bit parallel bus. That bus feeds the temperature PIO input port that the Nios II software polls or takes edge interrupts from. A toggle output gives the PIO's rising-edge capture logic a per-sample event.

Parameters:
- CLK_DIV, 25, clk cycles per SCK half-period; legal range 1 or more (25 gives 1 MHz SCK at 50 MHz).
- SAMPLE_PERIOD, 50000000, clk cycles from one transfer start to the next when enable=1; legal range 1 or more.
- DATA_W, 16, bits shifted per transfer and width of temp_data.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 means run periodic sampling.
- start_now  in  1  single-cycle pulse; requests one transfer immediately.
- spi_miso  in  1  sensor serial data.
- spi_cs_n  out  1  sensor chip-select, active low.
- spi_sck  out  1  serial clock, idle low.
- temp_data  out  DATA_W  last completed sample.
- temp_valid  out  1  one-cycle pulse when temp_data updates.
- update_tgl  out  1  inverts on every temp_data update.
- busy  out  1  high from transfer start through CS_HOLD.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports named clk and reset_n.
- Reset values: spi_cs_n=1, spi_sck=0, temp_data=0, temp_valid=0, update_tgl=0, busy=0, FSM=IDLE, period counter=0.
- Reset mid-transfer: outputs return to their reset values immediately (asynchronously). The partial shift register is discarded and temp_data is cleared.
- FSM states are IDLE, WAIT, CS_SETUP, SHIFT, CS_HOLD, DONE.
- IDLE: start_now=1 goes to CS_SETUP. Otherwise enable=1 goes to CS_SETUP, so the first periodic transfer starts the cycle after enable rises.
- WAIT: the period counter runs. Go to CS_SETUP when the counter reaches SAMPLE_PERIOD-1 or when start_now=1. Go to IDLE when enable=0 and start_now=0.
- CS_SETUP: spi_cs_n=0, spi_sck=0 for CLK_DIV cycles, then go to SHIFT.
- SHIFT: spi_sck toggles every CLK_DIV cycles, for DATA_W full SCK periods.
  - On each SCK rising edge, spi_miso shifts into the LSB of the shift register (MSB arrives first).
  - After the last falling edge, go to CS_HOLD with spi_sck=0.
- CS_HOLD: spi_cs_n=0 for CLK_DIV cycles, then spi_cs_n=1 and go to DONE.
- DONE (1 cycle): temp_data <= shift register, temp_valid=1, update_tgl inverts. Next state is WAIT if enable=1, else IDLE.
- busy=1 in CS_SETUP, SHIFT and CS_HOLD only.
- Transfer latency from entering CS_SETUP to the temp_valid pulse is CLK_DIV*(2*DATA_W+2)+1 cycles.
- Period counter: loads 0 in the cycle the FSM enters CS_SETUP and counts every cycle after that. Period is measured start-to-start.
  - If SAMPLE_PERIOD is at most the transfer length, WAIT lasts 1 cycle and the next transfer follows back-to-back.
- start_now while busy or in DONE: ignored and not queued.
- start_now and period expiry in the same cycle: exactly one transfer.
- enable falling mid-transfer: the current transfer completes and temp_data updates, then the FSM goes to IDLE.
- The bit counter wraps only through the FSM. No transfer is ever shorter or longer than DATA_W bits.
- temp_data holds its value between updates; it is never partially updated.

Decomposition:
- Package temp_spi_pkg holds the state enum (IDLE..DONE) and localparams: XFER_CYCLES = CLK_DIV*(2*DATA_W+2)+1, and the counter widths via $clog2 of SAMPLE_PERIOD, CLK_DIV and DATA_W.
- One sub-module, temp_spi_tick: CLK_DIV prescaler producing a half-period tick. Enabled only in CS_SETUP, SHIFT and CS_HOLD; count restarts on entry to CS_SETUP.

Test Plan:
- CLK_DIV=2, DATA_W=16, sensor model drives 0x1A30; pulse start_now with enable=0 -> 16 SCK rising edges, temp_valid pulses 69 cycles after CS_SETUP entry, temp_data=0x1A30, update_tgl=1, FSM returns to IDLE.
- SAMPLE_PERIOD=200, enable=1, model returns 0x0001 then 0xFFFF -> spi_cs_n falling edges exactly 200 cycles apart, temp_data sequence 0x0001 then 0xFFFF, update_tgl 1 then 0.
- SAMPLE_PERIOD=10 (shorter than the 68-cycle transfer) -> back-to-back transfers with 1 WAIT cycle between DONE and the next CS_SETUP; no transfer truncated.
- start_now pulsed during SHIFT and in the same cycle as period expiry -> exactly one transfer each time; no extra spi_cs_n assertion.
- enable dropped at bit 5 of a transfer, model value 0x0C80 -> transfer completes, temp_data=0x0C80, FSM to IDLE, no further spi_cs_n activity over 1000 cycles.
- reset_n asserted mid-SHIFT with temp_data=0x0C80 -> spi_cs_n=1, spi_sck=0 and temp_data=0 with no clock edge; after release, IDLE with no transfer until enable or start_now.

Source files
------------

// File: rtl/temp_spi_pkg.sv
// Shared types and sizing helpers for the SPI temperature sampler.
package temp_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } state_e;

  localparam int unsigned DEF_CLK_DIV       = 25;
  localparam int unsigned DEF_SAMPLE_PERIOD = 50000000;
  localparam int unsigned DEF_DATA_W        = 16;

  localparam int unsigned XFER_CYCLES =
    DEF_CLK_DIV * (2 * DEF_DATA_W + 2) + 1;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned PER_W = cnt_w(DEF_SAMPLE_PERIOD);
  localparam int unsigned DIV_W = cnt_w(DEF_CLK_DIV);
  localparam int unsigned BIT_W = cnt_w(DEF_DATA_W);

endpackage

// File: rtl/temp_spi_tick.sv
// SCK half-period prescaler; restarts cleanly at each transfer start.
module temp_spi_tick
  import temp_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/temp_spi_sampler.sv
// Periodic / on-demand SPI temperature acquisition controller
// holding the last sample on a parallel bus for the PIO.
module temp_spi_sampler
  import temp_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV       = DEF_CLK_DIV,
  parameter int unsigned SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int unsigned DATA_W        = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              start_now,
  input  logic              spi_miso,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic [DATA_W-1:0] temp_data,
  output logic              temp_valid,
  output logic              update_tgl,
  output logic              busy
);

  localparam int unsigned PW = cnt_w(SAMPLE_PERIOD);
  localparam int unsigned BW = cnt_w(DATA_W);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  state_e            r_state;
  state_e            w_nxt;
  logic [PW-1:0]     r_per;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W:0]   w_shift_nxt;
  logic [DATA_W-1:0] r_data;
  logic              r_sck;
  logic              r_cs_n;
  logic              r_busy;
  logic              r_valid;
  logic              r_tgl;
  logic              w_tick;
  logic              w_in_xfer;
  logic              w_nxt_xfer;
  logic              w_enter;
  logic              w_per_done;
  logic              w_rise;
  logic              w_fall;

  assign w_in_xfer  = r_state inside {CS_SETUP, SHIFT, CS_HOLD};
  assign w_nxt_xfer = w_nxt inside {CS_SETUP, SHIFT, CS_HOLD};
  assign w_enter    = (w_nxt == CS_SETUP) && (r_state != CS_SETUP);
  assign w_per_done = (r_per == PER_LAST);
  assign w_rise     = (r_state == SHIFT) && w_tick && !r_sck;
  assign w_fall     = (r_state == SHIFT) && w_tick && r_sck;
  assign w_shift_nxt = {r_shift, spi_miso};

  temp_spi_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_en      (w_in_xfer),
    .i_restart (w_enter),
    .o_tick    (w_tick)
  );

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start_now || enable) w_nxt = CS_SETUP;
      end
      WAIT: begin
        if (start_now)       w_nxt = CS_SETUP;
        else if (!enable)    w_nxt = IDLE;
        else if (w_per_done) w_nxt = CS_SETUP;
      end
      CS_SETUP: begin
        if (w_tick) w_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_fall && (r_bit == BIT_LAST)) w_nxt = CS_HOLD;
      end
      CS_HOLD: begin
        if (w_tick) w_nxt = DONE;
      end
      DONE: begin
        w_nxt = enable ? WAIT : IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cs_n  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cs_n  <= !w_nxt_xfer;
      r_busy  <= w_nxt_xfer;
    end
  end

  // Start-to-start period; saturates so short periods give one WAIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_per <= '0;
    end else if (w_enter) begin
      r_per <= '0;
    end else if (!w_per_done) begin
      r_per <= r_per + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck   <= 1'b0;
      r_bit   <= '0;
      r_shift <= '0;
    end else if (r_state == SHIFT) begin
      if (w_tick) r_sck <= ~r_sck;
      if (w_rise) r_shift <= w_shift_nxt[DATA_W-1:0];
      if (w_fall && (r_bit != BIT_LAST)) r_bit <= r_bit + BW'(1);
    end else begin
      r_sck <= 1'b0;
      if (r_state == CS_SETUP) begin
        r_bit   <= '0;
        r_shift <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_tgl   <= 1'b0;
    end else begin
      r_valid <= (r_state == DONE);
      if (r_state == DONE) begin
        r_data <= r_shift;
        r_tgl  <= ~r_tgl;
      end
    end
  end

  assign spi_cs_n   = r_cs_n;
  assign spi_sck    = r_sck;
  assign temp_data  = r_data;
  assign temp_valid = r_valid;
  assign update_tgl = r_tgl;
  assign busy       = r_busy;

endmodule

// File: tb/tb_temp_spi_sampler.sv
// Bench for temp_spi_sampler: sensor model, event monitor and
// scenario tasks on a slow-period and a back-to-back instance.
module tb_temp_spi_sampler;

  localparam int CD   = 2;
  localparam int DW   = 16;
  localparam int SP0  = 200;
  localparam int SP1  = 10;
  localparam int XFER = CD * (2 * DW + 2) + 1;

  function automatic int gap_of(input int sp);
    return (sp > XFER) ? sp : XFER + 1;
  endfunction

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable    [2];
  logic        start_now [2];
  logic        miso      [2] = '{1'b0, 1'b0};
  logic        cs_n      [2];
  logic        sck       [2];
  logic        valid     [2];
  logic        tgl       [2];
  logic        busy      [2];
  logic [15:0] data      [2];

  int checks;
  int errors;
  int cyc = 0;

  logic [15:0] word_q [2][$];
  logic [15:0] got_q  [2][$];
  int          fall_q [2][$];
  int          vcyc_q [2][$];
  int          rcnt_q [2][$];
  logic        tgl_q  [2][$];
  int          rises  [2] = '{0, 0};
  int          nval   [2] = '{0, 0};
  int          bidx   [2] = '{0, 0};
  logic [15:0] cur    [2];
  logic        pcs    [2] = '{1'b1, 1'b1};
  logic        psck   [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  temp_spi_sampler #(
    .CLK_DIV(CD), .SAMPLE_PERIOD(SP0), .DATA_W(DW)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .enable(enable[0]), .start_now(start_now[0]),
    .spi_miso(miso[0]), .spi_cs_n(cs_n[0]),
    .spi_sck(sck[0]), .temp_data(data[0]),
    .temp_valid(valid[0]), .update_tgl(tgl[0]),
    .busy(busy[0])
  );

  temp_spi_sampler #(
    .CLK_DIV(CD), .SAMPLE_PERIOD(SP1), .DATA_W(DW)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .enable(enable[1]), .start_now(start_now[1]),
    .spi_miso(miso[1]), .spi_cs_n(cs_n[1]),
    .spi_sck(sck[1]), .temp_data(data[1]),
    .temp_valid(valid[1]), .update_tgl(tgl[1]),
    .busy(busy[1])
  );

  // Sensor: MSB out on CS fall, next bit after each SCK fall.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        word_q[k].delete(); got_q[k].delete();
        fall_q[k].delete(); vcyc_q[k].delete();
        rcnt_q[k].delete(); tgl_q[k].delete();
        rises[k] = 0;
        nval[k] = 0;
      end else begin
        if (pcs[k] && !cs_n[k]) begin
          fall_q[k].push_back(cyc);
          rises[k] = 0;
          cur[k] = (word_q[k].size() > 0) ?
                   word_q[k].pop_front() : 16'($urandom);
          bidx[k] = 15;
          miso[k] = cur[k][15];
        end
        if (!psck[k] && sck[k]) rises[k]++;
        if (psck[k] && !sck[k] && !cs_n[k]) begin
          bidx[k]--;
          if (bidx[k] >= 0) miso[k] = cur[k][bidx[k]];
        end
        if (!pcs[k] && cs_n[k]) rcnt_q[k].push_back(rises[k]);
        if (valid[k]) begin
          got_q[k].push_back(data[k]);
          vcyc_q[k].push_back(cyc);
          tgl_q[k].push_back(tgl[k]);
          nval[k]++;
        end
      end
      pcs[k]  = cs_n[k];
      psck[k] = sck[k];
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input int k);
    start_now[k] = 1'b1;
    idle(1);
    start_now[k] = 1'b0;
  endtask

  task automatic wait_valids(input int k, input int n,
                             input int budget, output bit ok);
    int t = 0;
    while (nval[k] < n && t < budget) begin
      idle(1);
      t++;
    end
    ok = (nval[k] >= n);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) idle(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      enable[k] = 1'b0;
      start_now[k] = 1'b0;
    end
    idle(3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cs_n[k] !== 1'b1 || sck[k] !== 1'b0) begin
        errors++;
        $display("FAIL rst_spi[%0d]: cs_n=%b sck=%b exp 1/0",
                 k, cs_n[k], sck[k]);
      end
      checks++;
      if (data[k] !== 16'h0) begin
        errors++;
        $display("FAIL rst_data[%0d]: got %h exp 0000", k, data[k]);
      end
      checks++;
      if ({valid[k], tgl[k], busy[k]} !== 3'b000) begin
        errors++;
        $display("FAIL rst_flags[%0d]: got %b%b%b exp 000",
                 k, valid[k], tgl[k], busy[k]);
      end
    end
    reset_n = 1'b1;
    idle(5);
    checks++;
    if (fall_q[0].size() + fall_q[1].size() !== 0) begin
      errors++;
      $display("FAIL rst_idle: cs falls %0d exp 0",
               fall_q[0].size() + fall_q[1].size());
    end
  endtask

  task automatic test_single_start();
    int bf = fall_q[0].size();
    int bv = nval[0];
    bit ok;
    word_q[0].push_back(16'h1A30);
    pulse_start(0);
    wait_valids(0, bv + 1, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout: valids %0d exp %0d", nval[0], bv + 1);
    end else begin
      checks++;
      if (got_q[0][bv] !== 16'h1A30) begin
        errors++;
        $display("FAIL single_data: got %h exp 1a30", got_q[0][bv]);
      end
      checks++;
      if (vcyc_q[0][bv] - fall_q[0][bf] !== XFER) begin
        errors++;
        $display("FAIL single_latency: got %0d exp %0d",
                 vcyc_q[0][bv] - fall_q[0][bf], XFER);
      end
      checks++;
      if (rcnt_q[0][bf] !== DW) begin
        errors++;
        $display("FAIL single_rises: got %0d exp %0d", rcnt_q[0][bf], DW);
      end
      checks++;
      if (tgl_q[0][bv] !== 1'b1) begin
        errors++;
        $display("FAIL single_tgl: got %b exp 1", tgl_q[0][bv]);
      end
    end
    idle(300);
    checks++;
    if (fall_q[0].size() !== bf + 1 || nval[0] !== bv + 1) begin
      errors++;
      $display("FAIL single_idle: falls %0d valids %0d exp %0d %0d",
               fall_q[0].size(), nval[0], bf + 1, bv + 1);
    end
    checks++;
    if (busy[0] !== 1'b0 || cs_n[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_quiet: busy=%b cs_n=%b exp 0/1",
               busy[0], cs_n[0]);
    end
  endtask

  task automatic test_random_starts();
    for (int i = 0; i < 4; i++) begin
      int bf = fall_q[0].size();
      int bv = nval[0];
      logic [15:0] w = 16'($urandom);
      bit ok;
      idle($urandom_range(0, 15));
      word_q[0].push_back(w);
      pulse_start(0);
      wait_valids(0, bv + 1, 200, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_timeout[%0d]: valids %0d", i, nval[0]);
      end else begin
        checks++;
        if (got_q[0][bv] !== w ||
            vcyc_q[0][bv] - fall_q[0][bf] !== XFER) begin
          errors++;
          $display("FAIL rand_xfer[%0d]: got %h lat %0d exp %h lat %0d",
                   i, got_q[0][bv], vcyc_q[0][bv] - fall_q[0][bf],
                   w, XFER);
        end
        checks++;
        if (tgl_q[0][bv] !== 1'((bv + 1) % 2)) begin
          errors++;
          $display("FAIL rand_tgl[%0d]: got %b exp %0d",
                   i, tgl_q[0][bv], (bv + 1) % 2);
        end
      end
    end
  endtask

  task automatic test_periodic();
    int bf = fall_q[0].size();
    int bv = nval[0];
    int e;
    bit ok;
    logic [15:0] w [4];
    w = '{16'h0001, 16'hFFFF, 16'($urandom), 16'($urandom)};
    for (int i = 0; i < 4; i++) word_q[0].push_back(w[i]);
    e = cyc;
    enable[0] = 1'b1;
    wait_valids(0, bv + 4, 4 * SP0 + 100, ok);
    enable[0] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL per_timeout: valids %0d exp %0d", nval[0], bv + 4);
    end else begin
      checks++;
      if (fall_q[0][bf] !== e + 1) begin
        errors++;
        $display("FAIL per_first: cs fall at %0d exp %0d",
                 fall_q[0][bf], e + 1);
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (fall_q[0][bf+i] - fall_q[0][bf+i-1] !== gap_of(SP0)) begin
          errors++;
          $display("FAIL per_gap[%0d]: got %0d exp %0d", i,
                   fall_q[0][bf+i] - fall_q[0][bf+i-1], gap_of(SP0));
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[0][bv+i] !== w[i] ||
            tgl_q[0][bv+i] !== 1'((bv + i + 1) % 2)) begin
          errors++;
          $display("FAIL per_data[%0d]: got %h tgl %b exp %h tgl %0d",
                   i, got_q[0][bv+i], tgl_q[0][bv+i], w[i],
                   (bv + i + 1) % 2);
        end
      end
    end
    idle(400);
    checks++;
    if (fall_q[0].size() !== bf + 4) begin
      errors++;
      $display("FAIL per_stop: falls %0d exp %0d",
               fall_q[0].size(), bf + 4);
    end
  endtask

  task automatic test_back_to_back();
    int bf = fall_q[1].size();
    int bv = nval[1];
    int e;
    bit ok;
    logic [15:0] w [3];
    for (int i = 0; i < 3; i++) begin
      w[i] = 16'($urandom);
      word_q[1].push_back(w[i]);
    end
    e = cyc;
    enable[1] = 1'b1;
    wait_valids(1, bv + 3, 3 * gap_of(SP1) + 50, ok);
    enable[1] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout: valids %0d exp %0d", nval[1], bv + 3);
    end else begin
      checks++;
      if (fall_q[1][bf] !== e + 1) begin
        errors++;
        $display("FAIL b2b_first: cs fall at %0d exp %0d",
                 fall_q[1][bf], e + 1);
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (fall_q[1][bf+i] - fall_q[1][bf+i-1] !== gap_of(SP1)) begin
          errors++;
          $display("FAIL b2b_gap[%0d]: got %0d exp %0d", i,
                   fall_q[1][bf+i] - fall_q[1][bf+i-1], gap_of(SP1));
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[1][bv+i] !== w[i] || rcnt_q[1][bf+i] !== DW) begin
          errors++;
          $display("FAIL b2b_xfer[%0d]: got %h rises %0d exp %h %0d",
                   i, got_q[1][bv+i], rcnt_q[1][bf+i], w[i], DW);
        end
      end
    end
    idle(200);
    checks++;
    if (fall_q[1].size() !== got_q[1].size() ||
        rcnt_q[1].size() !== got_q[1].size()) begin
      errors++;
      $display("FAIL b2b_complete: falls %0d rises_q %0d valids %0d",
               fall_q[1].size(), rcnt_q[1].size(), got_q[1].size());
    end
  endtask

  task automatic test_start_collisions();
    int bf = fall_q[0].size();
    int bv = nval[0];
    int t = 0;
    int f1;
    bit ok;
    pulse_start(0);
    while ((fall_q[0].size() == bf || rises[0] < 4) && t < 100) begin
      idle(1);
      t++;
    end
    pulse_start(0);
    wait_valids(0, bv + 1, 200, ok);
    idle(200);
    checks++;
    if (!ok || fall_q[0].size() !== bf + 1 || nval[0] !== bv + 1) begin
      errors++;
      $display("FAIL start_in_shift: falls %0d valids %0d exp %0d %0d",
               fall_q[0].size(), nval[0], bf + 1, bv + 1);
    end
    bf = fall_q[0].size();
    f1 = cyc + 1;
    enable[0] = 1'b1;
    wait_cyc(f1 + XFER - 1);
    pulse_start(0);
    wait_cyc(f1 + SP0 - 1);
    pulse_start(0);
    wait_cyc(f1 + 2 * SP0 + 20);
    enable[0] = 1'b0;
    idle(200);
    checks++;
    if (fall_q[0].size() !== bf + 3) begin
      errors++;
      $display("FAIL collide_count: falls %0d exp %0d",
               fall_q[0].size() - bf, 3);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (fall_q[0][bf+i] !== f1 + i * SP0) begin
          errors++;
          $display("FAIL collide_time[%0d]: got %0d exp %0d",
                   i, fall_q[0][bf+i], f1 + i * SP0);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    int bf = fall_q[0].size();
    int bv = nval[0];
    int t = 0;
    bit ok;
    word_q[0].push_back(16'h0C80);
    enable[0] = 1'b1;
    while ((fall_q[0].size() == bf || rises[0] < 5) && t < 100) begin
      idle(1);
      t++;
    end
    enable[0] = 1'b0;
    wait_valids(0, bv + 1, 200, ok);
    checks++;
    if (!ok || got_q[0][bv] !== 16'h0C80) begin
      errors++;
      $display("FAIL drop_data: valids %0d data %h exp 0c80",
               nval[0] - bv, data[0]);
    end
    idle(1000);
    checks++;
    if (fall_q[0].size() !== bf + 1 || cs_n[0] !== 1'b1) begin
      errors++;
      $display("FAIL drop_idle: falls %0d cs_n %b exp 1 1",
               fall_q[0].size() - bf, cs_n[0]);
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    bit ok;
    logic [15:0] w = 16'($urandom);
    checks++;
    if (data[0] !== 16'h0C80) begin
      errors++;
      $display("FAIL mid_pre: data %h exp 0c80", data[0]);
    end
    pulse_start(0);
    while (rises[0] < 3 && t < 100) begin
      idle(1);
      t++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (cs_n[0] !== 1'b1 || sck[0] !== 1'b0 || data[0] !== 16'h0) begin
      errors++;
      $display("FAIL mid_async: cs_n %b sck %b data %h exp 1 0 0000",
               cs_n[0], sck[0], data[0]);
    end
    checks++;
    if ({busy[0], valid[0], tgl[0]} !== 3'b000) begin
      errors++;
      $display("FAIL mid_flags: got %b%b%b exp 000",
               busy[0], valid[0], tgl[0]);
    end
    idle(2);
    reset_n = 1'b1;
    idle(300);
    checks++;
    if (fall_q[0].size() !== 0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: falls %0d busy %b exp 0 0",
               fall_q[0].size(), busy[0]);
    end
    word_q[0].push_back(w);
    pulse_start(0);
    wait_valids(0, 1, 200, ok);
    checks++;
    if (!ok || data[0] !== w || tgl[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart: data %h tgl %b exp %h 1",
               data[0], tgl[0], w);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: cycle %0d exceeded time limit", cyc);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_start();
    test_random_starts();
    test_periodic();
    test_back_to_back();
    test_start_collisions();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
